// File: rtl/id_ex_if.sv
// ID/EX stage bus: decoded instruction from ID, hazard-unit controls,
// forwarding sources from EX/MEM and MEM/WB, and the execute-side outputs.
interface id_ex_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 3,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [DATA_W-1:0]     id_rs1_data;
  logic [DATA_W-1:0]     id_rs2_data;
  logic [DATA_W-1:0]     id_imm;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic [OP_W-1:0]       id_alu_op;
  logic                  id_alu_src_b;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_mem_to_reg;

  logic                  stall;
  logic                  flush;

  logic                  exm_reg_write;
  logic [REG_ADDR_W-1:0] exm_rd_addr;
  logic [DATA_W-1:0]     exm_result;
  logic                  mwb_reg_write;
  logic [REG_ADDR_W-1:0] mwb_rd_addr;
  logic [DATA_W-1:0]     mwb_result;

  logic                  ex_valid;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [OP_W-1:0]       alu_op;
  logic [DATA_W-1:0]     ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic                  load_use_hazard;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_rd_addr, id_alu_op, id_alu_src_b, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, stall, flush,
           exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_result,
    input  ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           load_use_hazard, stall_cnt, bubble_cnt
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data, id_imm,
           id_rd_addr, id_alu_op, id_alu_src_b, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, stall, flush,
           exm_reg_write, exm_rd_addr, exm_result,
           mwb_reg_write, mwb_rd_addr, mwb_result,
    output ex_valid, alu_a, alu_b, alu_op, ex_store_data, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           load_use_hazard, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection and saturating stall/bubble counters.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 3,
  parameter int CNT_W      = 16
) (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);

  logic                  ex_valid_d,    ex_valid_q;
  logic [REG_ADDR_W-1:0] rs1_addr_d,    rs1_addr_q;
  logic [REG_ADDR_W-1:0] rs2_addr_d,    rs2_addr_q;
  logic [DATA_W-1:0]     rs1_data_d,    rs1_data_q;
  logic [DATA_W-1:0]     rs2_data_d,    rs2_data_q;
  logic [DATA_W-1:0]     imm_d,         imm_q;
  logic [REG_ADDR_W-1:0] rd_addr_d,     rd_addr_q;
  logic [OP_W-1:0]       alu_op_d,      alu_op_q;
  logic                  alu_src_b_d,   alu_src_b_q;
  logic                  reg_write_d,   reg_write_q;
  logic                  mem_read_d,    mem_read_q;
  logic                  mem_write_d,   mem_write_q;
  logic                  mem_to_reg_d,  mem_to_reg_q;
  logic [CNT_W-1:0]      stall_cnt_d,   stall_cnt_q;
  logic [CNT_W-1:0]      bubble_cnt_d,  bubble_cnt_q;

  logic [DATA_W-1:0]     fwd_rs1;
  logic [DATA_W-1:0]     fwd_rs2;

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (bus.exm_reg_write && (bus.exm_rd_addr != '0) && (bus.exm_rd_addr == rs1_addr_q))
      fwd_rs1 = bus.exm_result;
    else if (bus.mwb_reg_write && (bus.mwb_rd_addr != '0) && (bus.mwb_rd_addr == rs1_addr_q))
      fwd_rs1 = bus.mwb_result;

    fwd_rs2 = rs2_data_q;
    if (bus.exm_reg_write && (bus.exm_rd_addr != '0) && (bus.exm_rd_addr == rs2_addr_q))
      fwd_rs2 = bus.exm_result;
    else if (bus.mwb_reg_write && (bus.mwb_rd_addr != '0) && (bus.mwb_rd_addr == rs2_addr_q))
      fwd_rs2 = bus.mwb_result;
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rd_addr_d    = rd_addr_q;
    alu_op_d     = alu_op_q;
    alu_src_b_d  = alu_src_b_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (bus.flush) begin
      ex_valid_d   = 1'b0;
      rs1_addr_d   = '0;
      rs2_addr_d   = '0;
      rs1_data_d   = '0;
      rs2_data_d   = '0;
      imm_d        = '0;
      rd_addr_d    = '0;
      alu_op_d     = '0;
      alu_src_b_d  = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      if (bubble_cnt_q != '1)
        bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else if (bus.stall) begin
      // Capture forwarded operands so a producer leaving MEM/WB mid-stall is not lost
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
      if (stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      ex_valid_d   = bus.id_valid;
      rs1_addr_d   = bus.id_rs1_addr;
      rs2_addr_d   = bus.id_rs2_addr;
      rs1_data_d   = bus.id_rs1_data;
      rs2_data_d   = bus.id_rs2_data;
      imm_d        = bus.id_imm;
      rd_addr_d    = bus.id_rd_addr;
      alu_op_d     = bus.id_alu_op;
      alu_src_b_d  = bus.id_alu_src_b;
      reg_write_d  = bus.id_reg_write;
      mem_read_d   = bus.id_mem_read;
      mem_write_d  = bus.id_mem_write;
      mem_to_reg_d = bus.id_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rd_addr_q    <= '0;
      alu_op_q     <= '0;
      alu_src_b_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rd_addr_q    <= rd_addr_d;
      alu_op_q     <= alu_op_d;
      alu_src_b_q  <= alu_src_b_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.alu_a         = fwd_rs1;
  assign bus.alu_b         = alu_src_b_q ? imm_q : fwd_rs2;
  assign bus.alu_op        = alu_op_q;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_rd_addr    = rd_addr_q;
  assign bus.ex_reg_write  = reg_write_q;
  assign bus.ex_mem_read   = mem_read_q;
  assign bus.ex_mem_write  = mem_write_q;
  assign bus.ex_mem_to_reg = mem_to_reg_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.bubble_cnt    = bubble_cnt_q;

  // Only flagged; the hazard unit decides to flush here and hold IF/ID
  assign bus.load_use_hazard = mem_read_q && ex_valid_q && (rd_addr_q != '0) && bus.id_valid &&
                               ((rd_addr_q == bus.id_rs1_addr) || (rd_addr_q == bus.id_rs2_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; counters are narrowed so saturation is reachable.
module tb_id_ex_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 3;
  localparam int CNT_W      = 4;
  localparam logic [31:0] CNT_MAX = 32'd15;

  localparam int S_VALID  = 0;
  localparam int S_ALU_A  = 1;
  localparam int S_ALU_B  = 2;
  localparam int S_OP     = 3;
  localparam int S_STORE  = 4;
  localparam int S_RD     = 5;
  localparam int S_RW     = 6;
  localparam int S_MR     = 7;
  localparam int S_HAZ    = 8;
  localparam int S_STALLC = 9;
  localparam int S_BUBC   = 10;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   checks;
  int   errors;
  logic [31:0] exp_stall;
  logic [31:0] exp_bubble;

  id_ex_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_VALID:  return {31'd0, bus.ex_valid};
      S_ALU_A:  return bus.alu_a;
      S_ALU_B:  return bus.alu_b;
      S_OP:     return {29'd0, bus.alu_op};
      S_STORE:  return bus.ex_store_data;
      S_RD:     return {27'd0, bus.ex_rd_addr};
      S_RW:     return {31'd0, bus.ex_reg_write};
      S_MR:     return {31'd0, bus.ex_mem_read};
      S_HAZ:    return {31'd0, bus.load_use_hazard};
      S_STALLC: return {28'd0, bus.stall_cnt};
      S_BUBC:   return {28'd0, bus.bubble_cnt};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expectVal(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                               input logic [4:0] rd, input logic [2:0] op, input logic src_b,
                               input logic rw, input logic mr, input logic mw, input logic m2r);
    bus.id_valid      = valid;
    bus.id_rs1_addr   = rs1;
    bus.id_rs2_addr   = rs2;
    bus.id_rs1_data   = d1;
    bus.id_rs2_data   = d2;
    bus.id_imm        = imm;
    bus.id_rd_addr    = rd;
    bus.id_alu_op     = op;
    bus.id_alu_src_b  = src_b;
    bus.id_reg_write  = rw;
    bus.id_mem_read   = mr;
    bus.id_mem_write  = mw;
    bus.id_mem_to_reg = m2r;
  endtask

  // One clock edge with the bench's counter model following flush/stall priority
  task automatic tick();
    if (bus.flush) begin
      if (exp_bubble != CNT_MAX) exp_bubble++;
    end else if (bus.stall) begin
      if (exp_stall != CNT_MAX) exp_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_stall  = 0;
    exp_bubble = 0;
    rst_n      = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.exm_reg_write = 1'b0;
    bus.exm_rd_addr   = '0;
    bus.exm_result    = '0;
    bus.mwb_reg_write = 1'b0;
    bus.mwb_rd_addr   = '0;
    bus.mwb_result    = '0;
    repeat (2) @(posedge clk);
    #1;
    expectVal("rst_valid", S_VALID, 0);
    expectVal("rst_alu_a", S_ALU_A, 0);
    expectVal("rst_alu_b", S_ALU_B, 0);
    expectVal("rst_op", S_OP, 0);
    expectVal("rst_stall_cnt", S_STALLC, 0);
    expectVal("rst_bubble_cnt", S_BUBC, 0);
    checkOutput();
    rst_n = 1'b1;

    // forwarding priority
    applyStimulus(1, 5, 6, 32'h55, 32'h66, 0, 7, 3'b010, 0, 1, 0, 0, 0);
    tick();
    bus.exm_reg_write = 1'b1; bus.exm_rd_addr = 5; bus.exm_result = 32'h11;
    bus.mwb_reg_write = 1'b1; bus.mwb_rd_addr = 5; bus.mwb_result = 32'h22;
    #1;
    expectVal("fwd_exm_wins", S_ALU_A, 32'h11);
    expectVal("fwd_no_match_b", S_ALU_B, 32'h66);
    expectVal("load_op", S_OP, 2);
    expectVal("load_rd", S_RD, 7);
    expectVal("load_valid", S_VALID, 1);
    checkOutput();
    bus.exm_reg_write = 1'b0;
    #1;
    expectVal("fwd_mwb", S_ALU_A, 32'h22);
    checkOutput();
    applyStimulus(1, 0, 6, 0, 32'h66, 0, 7, 3'b010, 0, 1, 0, 0, 0);
    bus.exm_reg_write = 1'b1; bus.exm_rd_addr = 0;
    bus.mwb_reg_write = 1'b1; bus.mwb_rd_addr = 0;
    tick();
    expectVal("fwd_r0_never", S_ALU_A, 0);
    checkOutput();

    // immediate path
    bus.exm_reg_write = 1'b0; bus.mwb_reg_write = 1'b0;
    applyStimulus(1, 1, 9, 0, 32'h99, 32'hFFFF_FFFC, 4, 3'b110, 1, 1, 0, 0, 0);
    tick();
    bus.exm_reg_write = 1'b1; bus.exm_rd_addr = 9; bus.exm_result = 32'h7;
    #1;
    expectVal("imm_alu_b", S_ALU_B, 32'hFFFF_FFFC);
    expectVal("store_fwd", S_STORE, 32'h7);
    checkOutput();
    bus.exm_reg_write = 1'b0;

    // load-use
    applyStimulus(1, 2, 0, 32'h20, 0, 4, 3, 3'b010, 1, 1, 1, 0, 1);
    tick();
    applyStimulus(1, 1, 3, 0, 0, 0, 5, 3'b010, 0, 1, 0, 0, 0);
    #1;
    expectVal("lu_hazard", S_HAZ, 1);
    expectVal("lu_mem_read", S_MR, 1);
    checkOutput();
    bus.id_rs2_addr = 4;
    #1;
    expectVal("lu_no_hazard", S_HAZ, 0);
    checkOutput();
    bus.id_rs2_addr = 3;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    expectVal("lu_flush_valid", S_VALID, 0);
    expectVal("lu_flush_mr", S_MR, 0);
    expectVal("lu_flush_haz", S_HAZ, 0);
    expectVal("lu_bubble_cnt", S_BUBC, exp_bubble);
    checkOutput();

    // stall refresh from MEM/WB
    applyStimulus(1, 8, 0, 32'h1111, 0, 0, 10, 3'b011, 0, 1, 0, 0, 0);
    tick();
    bus.stall = 1'b1;
    bus.mwb_reg_write = 1'b1; bus.mwb_rd_addr = 8; bus.mwb_result = 32'hABCD;
    #1;
    expectVal("stall_fwd_live", S_ALU_A, 32'hABCD);
    checkOutput();
    tick();
    bus.mwb_reg_write = 1'b0;
    applyStimulus(1, 2, 2, 32'hDEAD, 32'hDEAD, 0, 12, 3'b001, 0, 1, 0, 0, 0);
    #1;
    expectVal("stall_captured", S_ALU_A, 32'hABCD);
    expectVal("stall_hold_rd", S_RD, 10);
    checkOutput();
    tick();
    bus.stall = 1'b0;
    #1;
    expectVal("release_alu_a", S_ALU_A, 32'hABCD);
    expectVal("release_op", S_OP, 3);
    expectVal("release_valid", S_VALID, 1);
    expectVal("stall_cnt", S_STALLC, exp_stall);
    checkOutput();

    // flush beats stall
    bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    bus.stall = 1'b0;
    expectVal("fs_valid", S_VALID, 0);
    expectVal("fs_stall_cnt", S_STALLC, exp_stall);
    expectVal("fs_bubble_cnt", S_BUBC, exp_bubble);
    checkOutput();

    // bubble counter saturation
    repeat (13) tick();
    expectVal("bubble_at_max", S_BUBC, exp_bubble);
    checkOutput();
    repeat (3) tick();
    bus.flush = 1'b0;
    expectVal("bubble_sat", S_BUBC, CNT_MAX);
    expectVal("bubble_sat_stall", S_STALLC, exp_stall);
    checkOutput();

    // async reset mid-stream
    applyStimulus(1, 1, 2, 32'h5, 32'h6, 0, 9, 3'b111, 0, 1, 1, 0, 1);
    tick();
    expectVal("pre_rst_valid", S_VALID, 1);
    checkOutput();
    #2;
    rst_n = 1'b0;
    exp_stall  = 0;
    exp_bubble = 0;
    #1;
    expectVal("arst_valid", S_VALID, 0);
    expectVal("arst_rw", S_RW, 0);
    expectVal("arst_mr", S_MR, 0);
    expectVal("arst_op", S_OP, 0);
    expectVal("arst_stall_cnt", S_STALLC, exp_stall);
    expectVal("arst_bubble_cnt", S_BUBC, exp_bubble);
    checkOutput();
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
